pipe_hazard_sequencer: RTL and testbench

Central sequencing and hazard controller for the 5-stage RSA pipeline CPU (F/D/E/M/W). A run-state FSM gates fetch: idle until start, run, drain on halt, then done. While running it produces load-use stalls, taken-branch flushes with a multi-cycle flush window, and E-stage forwarding selects. It also keeps a cycle counter for RSA benchmark timing. It drives the PC register enable and the pipeline-register stall/flush inputs.

---
 rtl/pipe_hazard_sequencer.sv | 137 +++++++++++++
 tb/tb_pipe_hazard_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_sequencer.sv
// pipe_hazard_sequencer: run-state FSM, hazard detection and E-stage
// forwarding control for the 5-stage F/D/E/M/W pipeline, plus a
// RUN+DRAIN cycle counter used for benchmark timing.
module pipe_hazard_sequencer #(
  parameter int unsigned REG_BITS     = 4,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                halt_req,
  input  logic                BranchTakenE,
  input  logic                MemtoRegE,
  input  logic [REG_BITS-1:0] WA3E,
  input  logic [REG_BITS-1:0] WA3M,
  input  logic [REG_BITS-1:0] WA3W,
  input  logic                RegWriteM,
  input  logic                RegWriteW,
  input  logic [REG_BITS-1:0] RA1D,
  input  logic [REG_BITS-1:0] RA2D,
  input  logic [REG_BITS-1:0] RA1E,
  input  logic [REG_BITS-1:0] RA2E,
  output logic                StallF,
  output logic                StallD,
  output logic                FlushD,
  output logic                FlushE,
  output logic [1:0]          ForwardAE,
  output logic [1:0]          ForwardBE,
  output logic                running,
  output logic                done,
  output logic [31:0]         cycle_count
);

  localparam int unsigned FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int unsigned DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [FCW-1:0]      FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);
  localparam logic [DCW-1:0]      DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);
  localparam logic [REG_BITS-1:0] PC_REG     = REG_BITS'(15);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         state_q;
  logic [FCW-1:0] flush_cnt_q;
  logic [DCW-1:0] drain_cnt_q;
  logic [31:0]    cycle_count_q;

  logic lwstall;
  logic branch_now;

  assign lwstall    = MemtoRegE & ((WA3E == RA1D) | (WA3E == RA2D));
  // A branch only registers when no flush window is open; inside the window
  // the E slot holds a bubble, so BranchTakenE there is spurious.
  assign branch_now = BranchTakenE & (flush_cnt_q == '0);

  // Run-state FSM, flush-window and drain counters, benchmark cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      flush_cnt_q   <= '0;
      drain_cnt_q   <= '0;
      cycle_count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q       <= S_RUN;
            cycle_count_q <= '0;
          end
        end
        S_RUN: begin
          cycle_count_q <= cycle_count_q + 32'd1;
          if (halt_req) begin
            state_q     <= S_DRAIN;
            drain_cnt_q <= DRAIN_LOAD;
            flush_cnt_q <= '0;
          end else if (branch_now) begin
            flush_cnt_q <= FLUSH_LOAD;
          end else if (flush_cnt_q != '0) begin
            flush_cnt_q <= flush_cnt_q - FCW'(1);
          end
        end
        S_DRAIN: begin
          cycle_count_q <= cycle_count_q + 32'd1;
          if (drain_cnt_q == '0) begin
            state_q <= S_DONE;
          end else begin
            drain_cnt_q <= drain_cnt_q - DCW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Pipeline stall/flush controls decoded from state and current hazards.
  always_comb begin
    StallF = 1'b1;
    StallD = 1'b0;
    FlushD = 1'b1;
    FlushE = 1'b1;
    case (state_q)
      S_RUN: begin
        // A taken branch squashes the stalled instructions anyway, so it
        // overrides the load-use stall.
        StallF = lwstall & ~branch_now;
        StallD = lwstall & ~branch_now;
        FlushD = branch_now | (flush_cnt_q != '0);
        FlushE = branch_now | lwstall;
      end
      S_DRAIN: begin
        FlushE = 1'b0;
      end
      default: ;
    endcase
  end

  // E-stage forwarding selects; M result has priority, R15 is never forwarded.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && (WA3M == RA1E) && (RA1E != PC_REG))      ForwardAE = 2'b10;
    else if (RegWriteW && (WA3W == RA1E) && (RA1E != PC_REG)) ForwardAE = 2'b01;
    if (RegWriteM && (WA3M == RA2E) && (RA2E != PC_REG))      ForwardBE = 2'b10;
    else if (RegWriteW && (WA3W == RA2E) && (RA2E != PC_REG)) ForwardBE = 2'b01;
  end

  assign running     = (state_q == S_RUN) | (state_q == S_DRAIN);
  assign done        = (state_q == S_DONE);
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// Directed testbench for pipe_hazard_sequencer: a vector table for the
// RUN-state hazard/forwarding decode plus hand sequences for start, branch
// flush windows, halt/drain, restart and asynchronous reset.
module tb_pipe_hazard_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, halt_req, BranchTakenE, MemtoRegE;
  logic [3:0] WA3E, WA3M, WA3W, RA1D, RA2D, RA1E, RA2E;
  logic       RegWriteM, RegWriteW;
  logic       StallF, StallD, FlushD, FlushE, running, done;
  logic [1:0] ForwardAE, ForwardBE;
  logic [31:0] cycle_count;

  int checks   = 0;
  int failures = 0;

  pipe_hazard_sequencer #(
    .REG_BITS    (4),
    .FLUSH_CYCLES(2),
    .DRAIN_CYCLES(3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .halt_req    (halt_req),
    .BranchTakenE(BranchTakenE),
    .MemtoRegE   (MemtoRegE),
    .WA3E        (WA3E),
    .WA3M        (WA3M),
    .WA3W        (WA3W),
    .RegWriteM   (RegWriteM),
    .RegWriteW   (RegWriteW),
    .RA1D        (RA1D),
    .RA2D        (RA2D),
    .RA1E        (RA1E),
    .RA2E        (RA2E),
    .StallF      (StallF),
    .StallD      (StallD),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .ForwardAE   (ForwardAE),
    .ForwardBE   (ForwardBE),
    .running     (running),
    .done        (done),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       mem;
    logic [3:0] wa3e, ra1d, ra2d;
    logic       br;
    logic       rwm;
    logic [3:0] wa3m;
    logic       rww;
    logic [3:0] wa3w, ra1e, ra2e;
    logic       sF, sD, fD, fE;
    logic [1:0] fae, fbe;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 1'b0; halt_req = 1'b0; BranchTakenE = 1'b0; MemtoRegE = 1'b0;
    WA3E = '0; WA3M = '0; WA3W = '0; RA1D = '0; RA2D = '0; RA1E = '0; RA2E = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0;
  endtask

  task automatic chk_ctl(input string nm, input logic sF, input logic sD,
                         input logic fD, input logic fE);
    chk({nm, ".StallF"}, 32'(StallF), 32'(sF));
    chk({nm, ".StallD"}, 32'(StallD), 32'(sD));
    chk({nm, ".FlushD"}, 32'(FlushD), 32'(fD));
    chk({nm, ".FlushE"}, 32'(FlushE), 32'(fE));
  endtask

  initial begin
    //        name            mem   wa3e  ra1d  ra2d  br    rwm   wa3m  rww   wa3w  ra1e  ra2e   sF    sD    fD    fE    fae    fbe
    vecs[0]  = '{"quiet",       1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    vecs[1]  = '{"lw_ra2",      1'b1, 4'd3, 4'd0, 4'd3, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00};
    vecs[2]  = '{"lw_ra1",      1'b1, 4'd7, 4'd7, 4'd2, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00};
    vecs[3]  = '{"lw_nomatch",  1'b1, 4'd3, 4'd4, 4'd4, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    vecs[4]  = '{"match_noload",1'b0, 4'd3, 4'd3, 4'd3, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    vecs[5]  = '{"br_over_lw",  1'b1, 4'd3, 4'd0, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00};
    vecs[6]  = '{"fwd_m_pri",   1'b0, 4'd0, 4'd1, 4'd2, 1'b0, 1'b1, 4'd5, 1'b1, 4'd5, 4'd5, 4'd6,  1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00};
    vecs[7]  = '{"fwd_m_w",     1'b0, 4'd0, 4'd1, 4'd2, 1'b0, 1'b1, 4'd5, 1'b1, 4'd6, 4'd5, 4'd6,  1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01};
    vecs[8]  = '{"fwd_r15",     1'b0, 4'd0, 4'd1, 4'd2, 1'b0, 1'b1, 4'd15,1'b1, 4'd15,4'd15,4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    vecs[9]  = '{"fwd_w_b",     1'b0, 4'd0, 4'd1, 4'd2, 1'b0, 1'b1, 4'd15,1'b1, 4'd4, 4'd15,4'd4,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01};
    vecs[10] = '{"fwd_nowrite", 1'b0, 4'd0, 4'd1, 4'd2, 1'b0, 1'b0, 4'd8, 1'b0, 4'd8, 4'd8, 4'd8,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    vecs[11] = '{"branch",      1'b0, 4'd0, 4'd1, 4'd2, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00};

    clear_inputs();
    reset = 1'b1;
    #12;
    // Reset state, plus forwarding active outside RUN.
    chk_ctl("rst", 1'b1, 1'b0, 1'b1, 1'b1);
    chk("rst.running", 32'(running), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.count", cycle_count, 32'd0);
    RegWriteW = 1'b1; WA3W = 4'd9; RA2E = 4'd9;
    #1 chk("idle.ForwardBE", 32'(ForwardBE), 32'(2'b01));
    clear_inputs();
    reset = 1'b0;
    tick(); tick();
    chk("idle_hold.StallF", 32'(StallF), 32'd1);
    chk("idle_hold.count", cycle_count, 32'd0);

    // Start pulse: RUN on the next edge, counter starts at 0.
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    chk_ctl("run0", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("run0.running", 32'(running), 32'd1);
    chk("run0.count", cycle_count, 32'd0);
    tick(); chk("run1.count", cycle_count, 32'd1);
    tick(); chk("run2.count", cycle_count, 32'd2);

    // Table of RUN-state hazard and forwarding decodes (flush window idle).
    for (int i = 0; i < 12; i++) begin
      MemtoRegE = vecs[i].mem; WA3E = vecs[i].wa3e; RA1D = vecs[i].ra1d; RA2D = vecs[i].ra2d;
      BranchTakenE = vecs[i].br; RegWriteM = vecs[i].rwm; WA3M = vecs[i].wa3m;
      RegWriteW = vecs[i].rww; WA3W = vecs[i].wa3w; RA1E = vecs[i].ra1e; RA2E = vecs[i].ra2e;
      #1;
      chk_ctl(vecs[i].name, vecs[i].sF, vecs[i].sD, vecs[i].fD, vecs[i].fE);
      chk({vecs[i].name, ".ForwardAE"}, 32'(ForwardAE), 32'(vecs[i].fae));
      chk({vecs[i].name, ".ForwardBE"}, 32'(ForwardBE), 32'(vecs[i].fbe));
      clear_inputs();
      tick(); tick();
    end

    // Back-to-back branches: the second lands in the flush window and is ignored.
    BranchTakenE = 1'b1;
    #1 chk_ctl("br_c0", 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk_ctl("br_c1", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    BranchTakenE = 1'b0;
    #1 chk_ctl("br_c2", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Halt and drain; lwstall inputs and start must be ignored while draining.
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    MemtoRegE = 1'b1; start = 1'b1;
    for (int d = 0; d < 3; d++) begin
      #1;
      chk_ctl($sformatf("drain%0d", d), 1'b1, 1'b0, 1'b1, 1'b0);
      chk($sformatf("drain%0d.running", d), 32'(running), 32'd1);
      chk($sformatf("drain%0d.done", d), 32'(done), 32'd0);
      start = 1'b0;
      tick();
    end
    clear_inputs();
    #1;
    chk_ctl("done", 1'b1, 1'b0, 1'b1, 1'b1);
    chk("done.done", 32'(done), 32'd1);
    chk("done.running", 32'(running), 32'd0);

    // Restart from DONE; halt is sampled on the edge that brings the count to
    // 10, giving three DRAIN cycles and a held count of 13.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart.count", cycle_count, 32'd0);
    chk("restart.running", 32'(running), 32'd1);
    for (int k = 0; k < 9; k++) tick();
    chk("pre_halt.count", cycle_count, 32'd9);
    halt_req = 1'b1; BranchTakenE = 1'b1; MemtoRegE = 1'b1;
    tick();
    clear_inputs();
    #1;
    chk_ctl("halt_pri", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("halt_pri.count", cycle_count, 32'd10);
    tick(); tick(); tick();
    chk("done2.done", 32'(done), 32'd1);
    chk("done2.count", cycle_count, 32'd13);
    tick(); tick();
    chk("done2_hold.count", cycle_count, 32'd13);

    // Halt must have dropped the branch: no leftover FlushD after restart.
    start = 1'b1;
    tick();
    start = 1'b0;
    #1 chk_ctl("restart2", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("restart2.count", cycle_count, 32'd0);

    // Asynchronous reset in the middle of DRAIN.
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("pre_rst.running", 32'(running), 32'd1);
    #3 reset = 1'b1;
    #1;
    chk_ctl("async_rst", 1'b1, 1'b0, 1'b1, 1'b1);
    chk("async_rst.running", 32'(running), 32'd0);
    chk("async_rst.count", cycle_count, 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst.running", 32'(running), 32'd0);
    chk("post_rst.done", 32'(done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
